trace_scheduler: RTL and testbench

Sequences the per-line ray tracer against the VGA raster produced by the sync generator.
- Issues one trace request per visible line, two lines ahead of display, so the tracer fills the back half of a double-buffered line buffer.
- Swaps the line buffers at each line boundary and counts overruns when the tracer misses its deadline.
- Grants host configuration-register updates once per frame, during vertical blank, while the tracer is idle.

---
 rtl/vga_timing_pkg.sv | 23 ++
 rtl/sat_counter.sv | 23 ++
 rtl/trace_scheduler.sv | 129 ++++++++++++
 tb/tb_trace_scheduler.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// VGA raster timing shared with the sync generator, plus the trace scheduler state encoding.
package vga_timing_pkg;

    localparam int unsigned HRES  = 640;
    localparam int unsigned HF    = 16;
    localparam int unsigned HS    = 96;
    localparam int unsigned HB    = 48;
    localparam int unsigned VRES  = 480;
    localparam int unsigned VF    = 10;
    localparam int unsigned VS    = 2;
    localparam int unsigned VB    = 33;

    localparam int unsigned HFULL = HRES + HF + HS + HB;
    localparam int unsigned VFULL = VRES + VF + VS + VB;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StTracing,
        StDone
    } sched_state_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/trace_scheduler.sv
// Issues per-line trace requests two lines ahead of the raster, swaps line buffers at line
// boundaries, counts missed deadlines and grants host register loads once per vertical blank.
module trace_scheduler #(
    parameter int unsigned HRES  = vga_timing_pkg::HRES,
    parameter int unsigned HF    = vga_timing_pkg::HF,
    parameter int unsigned HS    = vga_timing_pkg::HS,
    parameter int unsigned HB    = vga_timing_pkg::HB,
    parameter int unsigned VRES  = vga_timing_pkg::VRES,
    parameter int unsigned VF    = vga_timing_pkg::VF,
    parameter int unsigned VS    = vga_timing_pkg::VS,
    parameter int unsigned VB    = vga_timing_pkg::VB,
    parameter int unsigned OVR_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [9:0]       i_h,
    input  logic [9:0]       i_v,
    output logic             o_trace_req,
    output logic [9:0]       o_trace_line,
    input  logic             i_trace_ack,
    input  logic             i_trace_done,
    output logic             o_buf_swap,
    output logic             o_vblank_start,
    input  logic             i_reg_load_req,
    output logic             o_reg_load,
    output logic             o_busy,
    output logic [OVR_W-1:0] o_overrun_count
);

    import vga_timing_pkg::*;

    localparam int unsigned HFull = HRES + HF + HS + HB;
    localparam int unsigned VFull = VRES + VF + VS + VB;
    localparam logic [9:0]  HLast = 10'(HFull - 1);
    localparam logic [9:0]  VLast = 10'(VFull - 1);
    localparam logic [9:0]  VVis  = 10'(VRES);
    localparam logic [9:0]  VEnd  = 10'(VRES - 1);

    sched_state_e r_state, w_state_d;
    logic [9:0]   r_trace_line, w_trace_line_d;
    logic         r_trace_req, r_buf_swap, r_vblank_start, r_reg_load, r_busy, r_grant_flag;
    logic         w_e, w_swap, w_ovr, w_issue, w_vblank, w_grant;
    logic [9:0]   w_n, w_t;

    // n: line displayed next; t: line two ahead, the one the tracer should fill.
    assign w_e      = (i_h == HLast);
    assign w_n      = (i_v == VLast) ? 10'd0 : i_v + 10'd1;
    assign w_t      = (w_n == VLast) ? 10'd0 : w_n + 10'd1;
    assign w_vblank = w_e && (i_v == VEnd);
    assign w_grant  = i_reg_load_req && (i_v >= VVis) && (i_v < VLast)
                      && (r_state == StIdle) && !r_grant_flag;

    always_comb begin
        w_state_d      = r_state;
        w_trace_line_d = r_trace_line;
        w_swap         = 1'b0;
        w_ovr          = 1'b0;
        w_issue        = 1'b0;

        unique case (r_state)
            StReq:     if (i_trace_ack)  w_state_d = StTracing;
            StTracing: if (i_trace_done) w_state_d = StDone;
            default:   ;
        endcase

        // A late trace keeps running; only the line boundary decides swap vs overrun.
        if (w_e) begin
            if ((r_state == StDone) || ((r_state == StTracing) && i_trace_done)) begin
                w_swap  = 1'b1;
                w_issue = 1'b1;
            end else if (((r_state == StReq) || (r_state == StTracing)) && (w_n < VVis)) begin
                w_ovr = 1'b1;
            end else if (r_state == StIdle) begin
                w_issue = 1'b1;
            end
        end

        if (w_issue) begin
            w_state_d = StIdle;
            if (w_t < VVis) begin
                w_state_d      = StReq;
                w_trace_line_d = w_t;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= StIdle;
            r_trace_line   <= '0;
            r_trace_req    <= 1'b0;
            r_buf_swap     <= 1'b0;
            r_vblank_start <= 1'b0;
            r_reg_load     <= 1'b0;
            r_busy         <= 1'b0;
            r_grant_flag   <= 1'b0;
        end else begin
            r_state        <= w_state_d;
            r_trace_line   <= w_trace_line_d;
            r_trace_req    <= (w_state_d == StReq);
            r_buf_swap     <= w_swap;
            r_vblank_start <= w_vblank;
            r_reg_load     <= w_grant;
            r_busy         <= (w_state_d != StIdle);
            if (w_grant) begin
                r_grant_flag <= 1'b1;
            end else if (w_vblank) begin
                r_grant_flag <= 1'b0;
            end
        end
    end

    sat_counter #(
        .W(OVR_W)
    ) u_overrun (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (w_ovr),
        .o_count (o_overrun_count)
    );

    assign o_trace_req    = r_trace_req;
    assign o_trace_line   = r_trace_line;
    assign o_buf_swap     = r_buf_swap;
    assign o_vblank_start = r_vblank_start;
    assign o_reg_load     = r_reg_load;
    assign o_busy         = r_busy;

endmodule

// File: tb/tb_trace_scheduler.sv
// Randomized scoreboard bench: a line-level reference model predicts every output cycle,
// a separate monitor compares the DUT against the predictions.
module tb_trace_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] i_h, i_v;
    logic       i_trace_ack, i_trace_done, i_reg_load_req;
    logic       o_trace_req, o_buf_swap, o_vblank_start, o_reg_load, o_busy;
    logic [9:0] o_trace_line;
    logic [7:0] o_overrun_count;

    always #5 clk = ~clk;

    trace_scheduler dut (
        .clk             (clk),
        .reset           (reset),
        .i_h             (i_h),
        .i_v             (i_v),
        .o_trace_req     (o_trace_req),
        .o_trace_line    (o_trace_line),
        .i_trace_ack     (i_trace_ack),
        .i_trace_done    (i_trace_done),
        .o_buf_swap      (o_buf_swap),
        .o_vblank_start  (o_vblank_start),
        .i_reg_load_req  (i_reg_load_req),
        .o_reg_load      (o_reg_load),
        .o_busy          (o_busy),
        .o_overrun_count (o_overrun_count)
    );

    typedef struct {
        longint cyc;
        bit     req;
        int     line;
        bit     swap;
        bit     vblank;
        bit     rload;
        bit     busy;
        int     ovr;
    } out_t;

    typedef struct {
        longint cyc;
        string  name;
        int     field;  // 0 busy, 1 trace_req, 2 overrun_count
        int     val;
    } dir_t;

    out_t   exp_q[$];
    dir_t   dir_q[$];
    longint cyc = 0;
    int     n_total = 0;
    int     n_bad = 0;
    int     n_timeouts = 0;
    bit     end_req = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: all comparisons and the summary live here.
    initial begin
        out_t e;
        dir_t d;
        int   got;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                n_total++;
                if (e.cyc != cyc || o_trace_req !== e.req || o_trace_line !== 10'(e.line) ||
                    o_buf_swap !== e.swap || o_vblank_start !== e.vblank ||
                    o_reg_load !== e.rload || o_busy !== e.busy ||
                    o_overrun_count !== 8'(e.ovr)) begin
                    n_bad++;
                    $display("FAIL out_vec cyc=%0d got req=%b line=%0d swap=%b vbl=%b rload=%b busy=%b ovr=%0d | want req=%b line=%0d swap=%b vbl=%b rload=%b busy=%b ovr=%0d",
                             cyc, o_trace_req, o_trace_line, o_buf_swap, o_vblank_start,
                             o_reg_load, o_busy, o_overrun_count, e.req, e.line, e.swap,
                             e.vblank, e.rload, e.busy, e.ovr);
                end
            end
            while (dir_q.size() > 0 && dir_q[0].cyc <= cyc) begin
                d = dir_q.pop_front();
                got = (d.field == 0) ? int'(o_busy) :
                      (d.field == 1) ? int'(o_trace_req) : int'(o_overrun_count);
                n_total++;
                if (got != d.val || d.cyc != cyc) begin
                    n_bad++;
                    $display("FAIL %s cyc=%0d got=%0d want=%0d", d.name, cyc, got, d.val);
                end
            end
            if (end_req) begin
                n_total++;
                if (exp_q.size() != 0 || dir_q.size() != 0) begin
                    n_bad++;
                    $display("FAIL leftover got=%0d want=0", exp_q.size() + dir_q.size());
                end
                n_total++;
                if (n_timeouts != 0) begin
                    n_bad++;
                    $display("FAIL wait_bound got=%0d want=0", n_timeouts);
                end
                $display("test done: total=%0d bad=%0d", n_total, n_bad);
                $finish;
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus, tracer and reference model ----------------
    int   r_h, r_v, line_len;
    bit   rst, rlr, rlr_forced, stuck;
    int   m_line, m_ovr, m_line_out;  // m_line: line in flight, -1 when none
    bit   m_acked, m_finished, m_flag;
    out_t exp_cur;
    int   tr_wait, tr_ack_dly, tr_run, tr_done_dly;

    task automatic new_line();
        line_len = $urandom_range(4, 12);
        r_h      = 800 - line_len;
    endtask

    task automatic adv_raster();
        if (r_h == 799) begin
            r_v = (r_v == 524) ? 0 : r_v + 1;
            new_line();
            if (!rlr_forced && $urandom_range(0, 29) == 0) rlr = !rlr;
        end else begin
            r_h++;
        end
    endtask

    task automatic issue(input int t);
        if (t < 480) begin
            m_line     = t;
            m_acked    = 1'b0;
            m_finished = 1'b0;
            m_line_out = t;
        end
    endtask

    task automatic model_eval(input bit rs, input int h, input int v, input bit ack,
                              input bit dn, input bit rl, output out_t nx);
        bit e, idle_now, finishing;
        int n, t;
        nx.cyc = cyc + 1;
        nx.swap = 0; nx.vblank = 0; nx.rload = 0;
        if (rs) begin
            m_line = -1; m_acked = 0; m_finished = 0; m_flag = 0; m_ovr = 0; m_line_out = 0;
        end else begin
            e         = (h == 799);
            n         = (v == 524) ? 0 : v + 1;
            t         = (n == 524) ? 0 : n + 1;
            idle_now  = (m_line < 0);
            finishing = m_finished || (m_line >= 0 && m_acked && dn);
            if (rl && v >= 480 && v < 524 && idle_now && !m_flag) begin
                nx.rload = 1; m_flag = 1;
            end
            if (e && v == 479) begin
                nx.vblank = 1; m_flag = 0;
            end
            if (e && finishing) begin
                nx.swap = 1;
                m_line = -1; m_acked = 0; m_finished = 0;
                issue(t);
            end else if (e && idle_now) begin
                issue(t);
            end else begin
                if (e && n < 480) m_ovr = (m_ovr >= 255) ? 255 : m_ovr + 1;
                if (m_line >= 0 && !m_acked && ack) m_acked = 1;
                else if (m_line >= 0 && m_acked && !m_finished && dn) m_finished = 1;
            end
        end
        nx.req  = (m_line >= 0) && !m_acked;
        nx.busy = (m_line >= 0);
        nx.line = m_line_out;
        nx.ovr  = m_ovr;
    endtask

    // Call at posedge+#1; returns at the next posedge+#1.
    task automatic do_cycle();
        bit   ack, dn;
        out_t nx;
        ack = 0; dn = 0;
        if (!rst) begin
            if (exp_cur.req) begin
                if (tr_wait == 0) begin
                    if ($urandom_range(0, 19) == 0) begin
                        tr_ack_dly = $urandom_range(4, 15); tr_done_dly = $urandom_range(6, 20);
                    end else begin
                        tr_ack_dly = $urandom_range(0, 2); tr_done_dly = $urandom_range(0, 3);
                    end
                end
                if (tr_wait >= tr_ack_dly) begin
                    ack = 1; tr_run = 0;
                end else begin
                    tr_wait++;
                    if ($urandom_range(0, 9) == 0) dn = 1;  // stray done while requesting
                end
            end else begin
                tr_wait = 0;
            end
            if (m_line >= 0 && m_acked && !m_finished) begin
                if (!stuck && tr_run >= tr_done_dly) dn = 1;
                else tr_run++;
            end
        end else begin
            tr_wait = 0; tr_run = 0;
        end
        reset          = rst;
        i_h            = 10'(r_h);
        i_v            = 10'(r_v);
        i_trace_ack    = ack;
        i_trace_done   = dn;
        i_reg_load_req = rlr;
        model_eval(rst, r_h, r_v, ack, dn, rlr, nx);
        exp_q.push_back(nx);
        exp_cur = nx;
        adv_raster();
        @(posedge clk);
        #1;
    endtask

    task automatic run_lines(input int nl);
        int cnt = 0;
        while (cnt < nl) begin
            if (r_h == 799) cnt++;
            do_cycle();
        end
    endtask

    task automatic push_dir(input string name, input int field, input int val);
        dir_t d;
        d.cyc = cyc + 1; d.name = name; d.field = field; d.val = val;
        dir_q.push_back(d);
    endtask

    initial begin
        int guard;
        reset = 1; i_h = 0; i_v = 0; i_trace_ack = 0; i_trace_done = 0; i_reg_load_req = 0;
        rst = 1; rlr = 0; rlr_forced = 0; stuck = 0;
        m_line = -1; m_acked = 0; m_finished = 0; m_flag = 0; m_ovr = 0; m_line_out = 0;
        exp_cur = '{default: 0};
        tr_wait = 0; tr_run = 0; tr_ack_dly = 0; tr_done_dly = 0;
        r_v = $urandom_range(0, 524);
        new_line();
        r_h = $urandom_range(0, 799);
        @(posedge clk);
        #1;
        repeat (4) do_cycle();
        push_dir("rst_busy", 0, 0);
        push_dir("rst_req", 1, 0);
        push_dir("rst_ovr", 2, 0);
        do_cycle();

        rst = 0; r_v = 0; new_line();
        run_lines(1050);

        // Tracer hangs in a trace across a whole frame: overruns saturate, no grants.
        stuck = 1; rlr_forced = 1; rlr = 1;
        run_lines(600);
        push_dir("ovr_sat", 2, 255);
        do_cycle();
        stuck = 0; rlr_forced = 0;
        run_lines(60);

        guard = 0;
        while (!(m_line >= 0 && m_acked && !m_finished) && guard < 3000) begin
            do_cycle();
            guard++;
        end
        if (guard >= 3000) n_timeouts++;
        rst = 1;
        push_dir("midrst_busy", 0, 0);
        push_dir("midrst_req", 1, 0);
        push_dir("midrst_ovr", 2, 0);
        do_cycle();
        do_cycle();
        rst = 0; r_v = $urandom_range(0, 524); new_line();
        run_lines(600);

        end_req = 1;
    end

endmodule
